mem_bridge: RTL
===============

Name: mem_bridge

Overview:
- Memory-mapped bus bridge directly downstream of the myCPU data port.
- Decodes the CPU bus address and routes each access to one target: DRAM, LED, digit display, switch, button, or timer registers.
- Owns the peripheral registers, a free-running programmable timer, and input synchronisers.
- Read data is returned combinationally in the same cycle, as the single-cycle core requires.

Parameters:
- DRAM_AW, 14: DRAM word-address width.
- TIMER_DIV_RST, 32'd0: reset value of the timer divisor (0 = timer stopped).

Ports:
- cpu_clk  in  1  system clock.
- cpu_rst  in  1  synchronous active-high reset.
- Bus_addr  in  32  byte address from the CPU.
- Bus_wen  in  1  write strobe, one access per cycle.
- Bus_wdata  in  32  write data.
- Bus_rdata  out  32  read data, combinational.
- dram_addr  out  DRAM_AW  word address, equal to Bus_addr[DRAM_AW+1:2].
- dram_wen  out  1  DRAM write enable.
- dram_wdata  out  32  equal to Bus_wdata.
- dram_rdata  in  32  DRAM read data, combinational.
- sw  in  24  asynchronous switches.
- btn  in  5  asynchronous buttons.
- led  out  24  LED register.
- dig_data  out  32  seven-segment display value register.

Behaviour:
- Clock/reset: one clock, cpu_clk. Reset cpu_rst is synchronous and active-high.
- Address map (exact-word match; low 2 bits ignored):
  - DRAM: 0x0000_0000–0x0000_FFFF (Bus_addr[31:16]==0).
  - DIG: 0xFFFF_F000, read/write.
  - TCNT: 0xFFFF_F020, read/write.
  - TDIV: 0xFFFF_F024, read/write.
  - LED: 0xFFFF_F060, read/write.
  - SW: 0xFFFF_F070, read-only, zero-extended.
  - BTN: 0xFFFF_F078, read-only, zero-extended.
- Unmapped addresses: reads return 0; writes are ignored.
- DRAM writes: dram_wen = Bus_wen & dram_hit. It must never assert for a peripheral address.
- Register writes: LED/DIG/TCNT/TDIV update on the cpu_clk edge when Bus_wen & hit. LED takes wdata[23:0].
- Register reads: return the current registered value. A write becomes visible on the next cycle's read.
- Writes to SW/BTN are ignored.
- Synchronisers:
  - sw and btn each pass through two flops.
  - Reads return the second-stage value: an input change appears on reads 2 cycles later.
- Timer state: 32-bit prescaler pre, count TCNT, divisor TDIV.
  - TDIV==0: pre and TCNT hold.
  - Otherwise, each cycle: if pre==TDIV-1 then pre<=0 and TCNT<=TCNT+1 (wraps 0xFFFF_FFFF→0); else pre<=pre+1.
  - TCNT write: TCNT<=wdata and pre<=0. The write takes priority over a coincident increment.
  - TDIV write: TDIV<=wdata and pre<=0. The new divisor applies from the next cycle.
  - TDIV=1: TCNT increments every cycle.
- Reset values:
  - led=0, dig_data=0, TCNT=0, pre=0, TDIV=TIMER_DIV_RST, synchroniser flops 0.
  - Bus_rdata follows the address mux and is not forced to 0 during reset.
  - Reset mid-operation discards any coincident write.
- Bus_rdata: pure mux of dram_rdata and the peripheral registers, with no added latency.

Decomposition:
- Package mem_bridge_pkg: address constants (ADDR_DIG, ADDR_TCNT, ADDR_TDIV, ADDR_LED, ADDR_SW, ADDR_BTN), the DRAM hit mask, and the target-select enum used by the read mux.
- Sub-module bridge_timer:
  - Contains pre/TCNT/TDIV plus write ports and count/div read outputs.
  - Isolates the only non-trivial sequential logic for unit test.
- Decode, registers, synchronisers and mux stay in mem_bridge.

Test Plan:
- DRAM pass-through:
  - Write addr 0x0000_0104, data 0xDEAD_BEEF → dram_wen=1, dram_addr=0x041, dram_wdata=0xDEAD_BEEF.
  - Read with dram_rdata=0x1234_5678 → Bus_rdata=0x1234_5678 in the same cycle.
- Peripheral write and isolation:
  - Write 0xFFFF_F060, data 0xFFAB_CDEF → next cycle led=0xABCDEF and dram_wen stays 0.
  - Read 0xFFFF_F060 → 0x00AB_CDEF.
  - Write 0xFFFF_F000, data 0x8765_4321 → dig_data=0x8765_4321.
- Synchroniser latency:
  - sw changes 0→0x00A5A5 at cycle N → reads of 0xFFFF_F070 return 0 at cycles N, N+1 and 0x0000_A5A5 from cycle N+2.
  - btn=5'h10 → read of 0xFFFF_F078 = 0x10.
- Timer divisor:
  - Write TDIV=4 → TCNT increments every 4 cycles: reads 1 after 4 cycles, 2 after 8.
  - Write TDIV=0 → TCNT freezes.
  - Write TDIV=1 → TCNT increments every cycle.
- Timer boundary:
  - Write TCNT=0xFFFF_FFFF with TDIV=1 → next cycle TCNT reads 0xFFFF_FFFF, the following cycle 0.
  - TCNT write coincident with a terminal prescale count → written value wins, pre=0.
- Unmapped/reset:
  - Read 0x8000_0000 → 0. Write 0x8000_0000 → no register or DRAM change.
  - Assert cpu_rst after led/dig/TCNT are loaded → all return to 0, TDIV to TIMER_DIV_RST.
  - A write presented during reset is discarded.

Source files
------------

// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared definitions for the CPU data-port bridge.
//   - Peripheral register byte addresses (matched on word address only).
//   - DRAM hit mask: an access is DRAM when the masked address is zero.
//   - Target-select enum used by the decoder and read mux.
//   - word_hit(): exact word match that ignores the two byte-lane bits.
package mem_bridge_pkg;

  localparam logic [31:0] ADDR_DIG  = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_TCNT = 32'hFFFF_F020;
  localparam logic [31:0] ADDR_TDIV = 32'hFFFF_F024;
  localparam logic [31:0] ADDR_LED  = 32'hFFFF_F060;
  localparam logic [31:0] ADDR_SW   = 32'hFFFF_F070;
  localparam logic [31:0] ADDR_BTN  = 32'hFFFF_F078;

  localparam logic [31:0] DRAM_HIT_MASK = 32'hFFFF_0000;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_DRAM,
    SEL_DIG,
    SEL_TCNT,
    SEL_TDIV,
    SEL_LED,
    SEL_SW,
    SEL_BTN
  } sel_e;

  function automatic logic word_hit(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:2] == base[31:2];
  endfunction

endpackage

// File: rtl/mem_bridge_timer.sv
// bridge_timer: free-running programmable timer.
//   clk, rst  : clock, synchronous active-high reset
//   cnt_we    : load count from wdata (clears prescaler)
//   div_we    : load divisor from wdata (clears prescaler)
//   wdata     : write data
//   count     : current TCNT value
//   div       : current TDIV value
// A divisor of 0 stops the timer; otherwise count advances once every
// div cycles. A divisor write takes effect from the following cycle, so the
// cycle carrying the write still ticks with the old divisor (only count can
// be affected by that tick; the prescaler is cleared by the write).
module bridge_timer #(
  parameter logic [31:0] DIV_RST = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cnt_we,
  input  logic        div_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] div
);

  logic [31:0] pre;
  logic [31:0] pre_next;
  logic [31:0] cnt_next;
  logic [31:0] div_next;

  always_comb begin
    pre_next = pre;
    cnt_next = count;
    div_next = div;
    if (div != '0) begin
      if (pre == div - 32'd1) begin
        pre_next = '0;
        cnt_next = count + 32'd1;
      end else begin
        pre_next = pre + 32'd1;
      end
    end
    // Software writes override the tick computed above.
    if (cnt_we) begin
      cnt_next = wdata;
      pre_next = '0;
    end
    if (div_we) begin
      div_next = wdata;
      pre_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre   <= '0;
      count <= '0;
      div   <= DIV_RST;
    end else begin
      pre   <= pre_next;
      count <= cnt_next;
      div   <= div_next;
    end
  end

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: memory-mapped bridge on the CPU data port.
//   cpu_clk, cpu_rst : clock, synchronous active-high reset
//   Bus_addr/Bus_wen/Bus_wdata/Bus_rdata : CPU bus (read data combinational)
//   dram_addr/dram_wen/dram_wdata/dram_rdata : DRAM word port
//   sw, btn  : asynchronous inputs, double-flop synchronised
//   led      : LED register (24 bits)
//   dig_data : seven-segment display value register
// Decodes each access to DRAM or one peripheral register; unmapped reads
// return 0 and unmapped writes are dropped.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int unsigned DRAM_AW       = 14,
  parameter logic [31:0] TIMER_DIV_RST = 32'd0
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [31:0]        Bus_addr,
  input  logic               Bus_wen,
  input  logic [31:0]        Bus_wdata,
  output logic [31:0]        Bus_rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_wen,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw,
  input  logic [4:0]         btn,
  output logic [23:0]        led,
  output logic [31:0]        dig_data
);

  sel_e        sel;
  logic [23:0] sw_meta;
  logic [23:0] sw_sync;
  logic [4:0]  btn_meta;
  logic [4:0]  btn_sync;
  logic [31:0] tcnt;
  logic [31:0] tdiv;
  logic        wr_dig;
  logic        wr_led;
  logic        wr_tcnt;
  logic        wr_tdiv;
  logic        addr_lo_unused;

  // Byte-lane bits play no part in decode.
  assign addr_lo_unused = ^Bus_addr[1:0];

  always_comb begin
    sel = SEL_NONE;
    if ((Bus_addr & DRAM_HIT_MASK) == '0)   sel = SEL_DRAM;
    else if (word_hit(Bus_addr, ADDR_DIG))  sel = SEL_DIG;
    else if (word_hit(Bus_addr, ADDR_TCNT)) sel = SEL_TCNT;
    else if (word_hit(Bus_addr, ADDR_TDIV)) sel = SEL_TDIV;
    else if (word_hit(Bus_addr, ADDR_LED))  sel = SEL_LED;
    else if (word_hit(Bus_addr, ADDR_SW))   sel = SEL_SW;
    else if (word_hit(Bus_addr, ADDR_BTN))  sel = SEL_BTN;
  end

  assign dram_addr  = Bus_addr[DRAM_AW+1:2];
  assign dram_wdata = Bus_wdata;
  assign dram_wen   = Bus_wen && (sel == SEL_DRAM);

  assign wr_dig  = Bus_wen && (sel == SEL_DIG);
  assign wr_led  = Bus_wen && (sel == SEL_LED);
  assign wr_tcnt = Bus_wen && (sel == SEL_TCNT);
  assign wr_tdiv = Bus_wen && (sel == SEL_TDIV);

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      led      <= '0;
      dig_data <= '0;
    end else begin
      if (wr_led) led      <= Bus_wdata[23:0];
      if (wr_dig) dig_data <= Bus_wdata;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      btn_meta <= btn;
      btn_sync <= btn_meta;
    end
  end

  bridge_timer #(
    .DIV_RST(TIMER_DIV_RST)
  ) u_timer (
    .clk    (cpu_clk),
    .rst    (cpu_rst),
    .cnt_we (wr_tcnt),
    .div_we (wr_tdiv),
    .wdata  (Bus_wdata),
    .count  (tcnt),
    .div    (tdiv)
  );

  always_comb begin
    Bus_rdata = '0;
    case (sel)
      SEL_DRAM: Bus_rdata = dram_rdata;
      SEL_DIG:  Bus_rdata = dig_data;
      SEL_TCNT: Bus_rdata = tcnt;
      SEL_TDIV: Bus_rdata = tdiv;
      SEL_LED:  Bus_rdata = {8'h00, led};
      SEL_SW:   Bus_rdata = {8'h00, sw_sync};
      SEL_BTN:  Bus_rdata = {27'h0, btn_sync};
      default:  Bus_rdata = '0;
    endcase
  end

endmodule
